d_latch: RTL and testbench
==========================

D_LATCH -- requirements
Module: d_latch

Interface
REQ-001 SHALL provide parameter WIDTH, default 1, data path width in bits (legal range 1..64).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset; the reset is synchronous and active-high.
REQ-004 SHALL provide port D  input  WIDTH  data input.
REQ-005 SHALL provide port E  input  1  enable (gate); high = transparent, low = hold.
REQ-006 SHALL provide port Q  output  WIDTH  latch output.

Function
REQ-007 SHALL hold an internal storage register "held" of WIDTH bits.
REQ-008 SHALL drive Q = D combinationally whenever E=1, with zero-cycle latency (transparent mode).
REQ-009 SHALL drive Q = held whenever E=0 (hold mode); changes on D while E=0 SHALL NOT affect Q.
REQ-010 SHALL load held <= D on every rising clk edge where E=1 and rst=0.
REQ-011 SHALL keep held unchanged on rising clk edges where E=0 and rst=0.
REQ-012 When E falls, Q SHALL hold the value captured at the last rising edge with E=1; the bench SHALL keep D stable for at least one clock edge before E falls.
REQ-013 Bits SHALL be independent: bit i of Q depends only on bit i of D, held and the shared E.
REQ-014 There SHALL be no X propagation from held after reset; before the first reset, Q in hold mode is undefined.

Reset
REQ-015 On a rising clk edge with rst=1, held SHALL become all zeros regardless of E and D.
REQ-016 Reset SHALL take priority over a simultaneous load (rst=1, E=1).
REQ-017 While rst=1 with E=1, Q SHALL still follow D (transparency is combinational); after reset with E=0, Q SHALL be 0.
REQ-018 Reset asserted mid-hold SHALL clear the held value at the next rising edge; the previously held value SHALL be lost.

Configuration
REQ-019 Macro D_LATCH_QN_EN: when defined, the module SHALL add output port Qn  output  WIDTH, equal to the bitwise complement of Q at all times, with a reset value of all ones in hold mode.
REQ-020 When D_LATCH_QN_EN is undefined, port Qn SHALL NOT exist, and the module SHALL otherwise behave identically.

Structure
REQ-021 Package d_latch_pkg SHALL hold the DEFAULT_WIDTH constant (1), the reset value constant (all zeros), and a typedef for the data word.
REQ-022 A sub-module d_latch_cell (1-bit: clk, rst, d, e, q[, qn]) SHALL be instantiated WIDTH times through a generate loop; d_latch SHALL contain only the generate loop and the port wiring.
REQ-023 The design SHALL contain no inferred level-sensitive latches; all storage SHALL be clk-edge flops.

Verification
REQ-024 Reset with E=0, D=0 -> Q=0 after the first edge; Qn=1 with D_LATCH_QN_EN.
REQ-025 E=1, D=0 for 1 cycle, then D=1 -> Q=0, then Q=1 immediately, without waiting for a clock edge.
REQ-026 D=1, E=1 for 1 edge, then E=0 with D=1, then D=0 -> Q stays 1 in both hold phases.
REQ-027 From hold Q=1, set E=1, D=0 -> Q=0 immediately; after 1 edge, set E=0 with D=0 -> Q holds 0.
REQ-028 Hold Q=1 (E=0), pulse rst for 1 edge -> Q=0 after that edge; simultaneous rst=1, E=1, D=1 -> held=0, and Q=0 once E drops.
REQ-029 WIDTH=8: E=1, D=0xA5, 1 edge, then E=0, D=0x3C -> Q=0xA5 until the next enable.

Source files
------------

// File: rtl/d_latch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : d_latch_pkg
//  Purpose  : Shared constants and types for the clocked D-latch block.
//             DEFAULT_WIDTH : default data path width (1 bit).
//             MAX_WIDTH     : widest supported data path (64 bits).
//             word_t        : data word type sized to MAX_WIDTH; narrower
//                             instances use the low WIDTH bits.
//             RESET_VALUE   : value loaded into the held register on reset.
//  Options  : none (the D_LATCH_QN_EN macro is consumed by d_latch and
//             d_latch_cell, not by this package).
//  Revision : 1.0 - initial release
// ============================================================================
package d_latch_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int MAX_WIDTH     = 64;

  typedef logic [MAX_WIDTH-1:0] word_t;

  localparam word_t RESET_VALUE = '0;

  // Reset value of a single bit lane, so cells do not need to know their
  // position in the word.
  function automatic logic reset_bit(input int unsigned idx);
    word_t v;
    v = RESET_VALUE;
    return v[idx];
  endfunction

endpackage : d_latch_pkg
`default_nettype wire

// File: rtl/d_latch_cell.sv
`default_nettype none
// ============================================================================
//  Module   : d_latch_cell
//  Purpose  : One bit lane of the clocked D latch. It behaves like a gated
//             latch (transparent while e=1, holding while e=0). The only
//             storage is an edge-triggered flop, so no level-sensitive latch
//             is inferred.
//  Ports    : clk  in  - clock; the held bit updates on its rising edge
//             rst  in  - synchronous active-high reset (clears held bit)
//             d    in  - data bit
//             e    in  - gate: 1 = transparent, 0 = hold
//             q    out - latch output
//             qn   out - complement of q (only with D_LATCH_QN_EN defined)
//  Options  : D_LATCH_QN_EN adds the qn output.
//  Revision : 1.0 - initial release
// ============================================================================
module d_latch_cell
  import d_latch_pkg::*;
#(
  parameter int unsigned LANE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic e,
`ifdef D_LATCH_QN_EN
  output logic q,
  output logic qn
`else
  output logic q
`endif
);

  localparam logic c_RST_BIT = reset_bit(LANE);

  logic held_q;
  logic held_d;

  // Capture d on each edge that the gate is open. Otherwise keep the
  // previous value.
  always_comb begin
    held_d = held_q;
    if (e) begin
      held_d = d;
    end
  end

  // Reset wins over a simultaneous load.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q <= c_RST_BIT;
    end else begin
      held_q <= held_d;
    end
  end

  // The output is transparent without a clock edge. d reaches q through
  // this mux even while rst is asserted.
  assign q = e ? d : held_q;

`ifdef D_LATCH_QN_EN
  assign qn = ~q;
`endif

endmodule : d_latch_cell
`default_nettype wire

// File: rtl/d_latch.sv
`default_nettype none
// ============================================================================
//  Module   : d_latch
//  Purpose  : WIDTH-bit clocked D latch built from independent 1-bit cells.
//             Q follows D while E=1. While E=0, Q shows the value captured
//             on the last rising clk edge that had E=1. Reset is synchronous
//             and active high, and it clears the held value.
//  Ports    : clk in  1     - clock
//             rst in  1     - synchronous active-high reset
//             D   in  WIDTH - data input
//             E   in  1     - enable/gate (1 = transparent, 0 = hold)
//             Q   out WIDTH - latch output
//             Qn  out WIDTH - ~Q (only with D_LATCH_QN_EN defined)
//  Params   : WIDTH - data width, 1..64 (default DEFAULT_WIDTH)
//  Options  : D_LATCH_QN_EN adds the complementary output Qn.
//  Revision : 1.0 - initial release
// ============================================================================
module d_latch
  import d_latch_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             E,
`ifdef D_LATCH_QN_EN
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
`else
  output logic [WIDTH-1:0] Q
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_latch_cell #(
      .LANE (i)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .d   (D[i]),
      .e   (E),
`ifdef D_LATCH_QN_EN
      .q   (Q[i]),
      .qn  (Qn[i])
`else
      .q   (Q[i])
`endif
    );
  end : g_bit

endmodule : d_latch
`default_nettype wire

// File: tb/tb_d_latch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_d_latch
//  Purpose  : Directed self-checking bench for d_latch with WIDTH=8. Each step
//             pushes the value Q must show, and the check pops that value and
//             compares it against the DUT output. With D_LATCH_QN_EN defined,
//             the check also covers Qn.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_d_latch;

  localparam int W = 8;

  typedef struct {
    string        tag;
    logic [W-1:0] exp;
  } sb_entry_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] D;
  logic         E;
  logic [W-1:0] Q;
`ifdef D_LATCH_QN_EN
  logic [W-1:0] Qn;
`endif

  sb_entry_t sb_q[$];
  int        checks;
  int        errors;

  d_latch #(
    .WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .D   (D),
    .E   (E),
`ifdef D_LATCH_QN_EN
    .Q   (Q),
    .Qn  (Qn)
`else
    .Q   (Q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge. Sampling happens 1 ns later, so it is
  // never on the edge itself.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_q(input string tag, input logic [W-1:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it against the current output.
  task automatic check_q();
    sb_entry_t e;
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: got no expectation, required one");
      return;
    end
    e = sb_q.pop_front();
    checks++;
    assert (Q === e.exp) else begin
      errors++;
      $error("FAIL %s: Q=%h required %h", e.tag, Q, e.exp);
    end
`ifdef D_LATCH_QN_EN
    checks++;
    assert (Qn === ~e.exp) else begin
      errors++;
      $error("FAIL %s_qn: Qn=%h required %h", e.tag, Qn, ~e.exp);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    E   = 1'b0;
    D   = '0;

    // Reset with the gate closed: held clears, so Q=0 (Qn all ones).
    tick();
    expect_q("reset_hold", 8'h00);          check_q();
    rst = 1'b0;

    // Transparent mode: Q follows D without a clock edge.
    E = 1'b1; D = 8'h00;
    expect_q("transp_d0", 8'h00);           check_q();
    tick();
    D = 8'hFF;
    expect_q("transp_d1_no_edge", 8'hFF);   check_q();
    tick();                                 // held = FF

    // Hold mode: D changes must not reach Q.
    E = 1'b0; D = 8'hFF;
    expect_q("hold_after_fall", 8'hFF);     check_q();
    tick();
    D = 8'h00;
    expect_q("hold_d_changed", 8'hFF);      check_q();
    tick();
    expect_q("hold_after_edge", 8'hFF);     check_q();

    // Re-open the gate with D=0, capture it, then hold 0.
    E = 1'b1; D = 8'h00;
    expect_q("reopen_d0", 8'h00);           check_q();
    tick();                                 // held = 00
    E = 1'b0;
    expect_q("hold_zero", 8'h00);           check_q();
    D = 8'hFF;
    expect_q("hold_zero_d_ff", 8'h00);      check_q();
    tick();
    expect_q("hold_zero_edge", 8'h00);      check_q();

    // Reset during hold loses the held value.
    E = 1'b1; D = 8'hFF;
    tick();                                 // held = FF
    E = 1'b0; D = 8'h00;
    expect_q("pre_reset_hold", 8'hFF);      check_q();
    rst = 1'b1;
    tick();
    expect_q("reset_mid_hold", 8'h00);      check_q();
    rst = 1'b0;

    // Reload FF, then assert reset and load together: reset has priority.
    E = 1'b1; D = 8'hFF;
    tick();                                 // held = FF
    rst = 1'b1;
    expect_q("rst_transp", 8'hFF);          check_q();
    tick();                                 // held = 00 (reset wins)
    expect_q("rst_transp_edge", 8'hFF);     check_q();
    rst = 1'b0; E = 1'b0;
    expect_q("rst_priority_hold", 8'h00);   check_q();
    tick();
    expect_q("rst_priority_edge", 8'h00);   check_q();

    // 8-bit pattern capture.
    E = 1'b1; D = 8'hA5;
    tick();                                 // held = A5
    E = 1'b0; D = 8'h3C;
    expect_q("w8_hold_a5", 8'hA5);          check_q();
    tick();
    D = 8'h5A;
    tick();
    expect_q("w8_hold_a5_edges", 8'hA5);    check_q();
    E = 1'b1; D = 8'h3C;
    expect_q("w8_next_enable", 8'h3C);      check_q();

    // Bit independence: complementary halves.
    D = 8'h0F;
    tick();                                 // held = 0F
    E = 1'b0; D = 8'hF0;
    expect_q("bits_indep", 8'h0F);          check_q();
    tick();
    expect_q("bits_indep_edge", 8'h0F);     check_q();

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover: got %0d entries, required 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_d_latch
`default_nettype wire
